// File: rtl/key_fifo_buffer_if.sv
// Keyboard-buffer bus: raw key lines and consumer command in, queue head and status out.
// The count width follows DEPTH, so DEPTH here must match the buffer's DEPTH.
interface key_fifo_buffer_if #(
   parameter int DEPTH = 8
);
   logic [15:0]              key_in;
   logic                     mode;
   logic [4:0]               eBCD;
   logic [$clog2(DEPTH):0]   count;
   logic                     full;
   logic                     overflow;
   logic                     ac_pulse;

   modport master (
      output key_in, mode,
      input  eBCD, count, full, overflow, ac_pulse
   );

   modport slave (
      input  key_in, mode,
      output eBCD, count, full, overflow, ac_pulse
   );
endinterface

// File: rtl/key_fifo_buffer.sv
// Calculator keyboard producer: debounces 16 key lines, encodes each accepted press
// and queues it in a small FIFO; the AC key flushes the queue instead of being queued.
module key_fifo_buffer #(
   parameter int DEPTH    = 8,
   parameter int DEBOUNCE = 4,
   parameter int CW       = 8
) (
   input  logic              sw_clk,
   input  logic              rst,
   key_fifo_buffer_if.slave  bus
);
   localparam int             AW       = $clog2(DEPTH);
   localparam logic [CW-1:0]  DB_CNT   = CW'(DEBOUNCE);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [3:0]     AC_CODE  = 4'hd;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [15:0]     sample_q, sample_d;
   logic            press_acc;
   logic [3:0]      press_code;

   logic [3:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            overflow_q, overflow_d;
   logic            ac_pulse_q, ac_pulse_d;
   logic            is_ac, push_req, push, pop;

   always_ff @(posedge sw_clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sample_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         ac_pulse_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sample_q   <= sample_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         ac_pulse_q <= ac_pulse_d;
      end
   end

   // Storage needs no reset: pointers and count decide what is visible.
   always_ff @(posedge sw_clk) begin
      if (push && !rst)
         mem_q[wr_ptr_q] <= press_code;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sample_d  = sample_q;
      press_acc = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.key_in != '0) begin
               sample_d = bus.key_in;
               if (DEBOUNCE == 1) begin
                  press_acc = 1'b1;
                  state_d   = HELD;
                  cnt_d     = '0;
               end else begin
                  state_d = PRESS_WAIT;
                  cnt_d   = CW'(1);
               end
            end
         end
         PRESS_WAIT: begin
            if (bus.key_in != sample_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_d == DB_CNT) begin
                  press_acc = 1'b1;
                  state_d   = HELD;
                  cnt_d     = '0;
               end
            end
         end
         HELD: begin
            if (bus.key_in == '0) begin
               if (DEBOUNCE == 1) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  state_d = RELEASE_WAIT;
                  cnt_d   = CW'(1);
               end
            end
         end
         RELEASE_WAIT: begin
            if (bus.key_in != '0) begin
               state_d = HELD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_d == DB_CNT) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Lowest set bit wins when several keys are caught in the same sample.
   always_comb begin
      press_code = 4'h0;
      for (int i = 15; i >= 0; i--) begin
         if (sample_d[i])
            press_code = 4'(i);
      end
   end

   always_comb begin
      is_ac      = press_acc && (press_code == AC_CODE);
      push_req   = press_acc && !is_ac;
      pop        = bus.mode && (count_q != '0) && !is_ac;
      push       = push_req && ((count_q != FULL_CNT) || pop);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      ac_pulse_d = is_ac;
      if (is_ac) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (push)
            wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)
            count_d = count_q + (AW+1)'(1);
         else if (pop && !push)
            count_d = count_q - (AW+1)'(1);
         if (push_req && !push)
            overflow_d = 1'b1;
      end
   end

   assign bus.eBCD     = (count_q != '0) ? {1'b1, mem_q[rd_ptr_q]} : 5'h00;
   assign bus.count    = count_q;
   assign bus.full     = (count_q == FULL_CNT);
   assign bus.overflow = overflow_q;
   assign bus.ac_pulse = ac_pulse_q;
endmodule

// File: tb/tb_key_fifo_buffer.sv
// Directed bench for key_fifo_buffer with DEPTH=4, DEBOUNCE=4.
module tb_key_fifo_buffer;
   logic sw_clk = 1'b0;
   logic rst;
   int   total  = 0;
   int   passed = 0;

   key_fifo_buffer_if #(.DEPTH(4)) bus ();

   key_fifo_buffer #(.DEPTH(4), .DEBOUNCE(4), .CW(8)) dut (
      .sw_clk (sw_clk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 sw_clk = ~sw_clk;

   task automatic step(input int n);
      repeat (n) @(posedge sw_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic press(input logic [15:0] key);
      bus.key_in = key;
      step(4);
   endtask

   task automatic release_key();
      bus.key_in = 16'h0000;
      step(6);
   endtask

   task automatic pop_one();
      bus.mode = 1'b1;
      step(1);
      bus.mode = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      bus.key_in = 16'h0000;
      bus.mode   = 1'b0;
      step(2);
      chk("rst_ebcd", 16'(bus.eBCD), 16'h00);
      chk("rst_count", 16'(bus.count), 16'd0);
      chk("rst_full", 16'(bus.full), 16'd0);
      chk("rst_ovf", 16'(bus.overflow), 16'd0);
      chk("rst_ac", 16'(bus.ac_pulse), 16'd0);
      rst = 1'b0;

      // Stable press of key 3
      bus.key_in = 16'h0008;
      step(3);
      chk("t1_early_count", 16'(bus.count), 16'd0);
      step(1);
      chk("t1_ebcd", 16'(bus.eBCD), 16'h13);
      chk("t1_count", 16'(bus.count), 16'd1);
      step(20);
      chk("t1_hold_count", 16'(bus.count), 16'd1);
      release_key();
      pop_one();
      chk("t1_pop_count", 16'(bus.count), 16'd0);
      $display("t1 single press done");

      // Bounce then settle
      for (int i = 0; i < 6; i++) begin
         bus.key_in = (i % 2 == 0) ? 16'h0008 : 16'h0000;
         step(1);
      end
      bus.key_in = 16'h0008;
      step(3);
      chk("t2_early_count", 16'(bus.count), 16'd0);
      step(1);
      chk("t2_count", 16'(bus.count), 16'd1);
      chk("t2_ebcd", 16'(bus.eBCD), 16'h13);
      release_key();
      pop_one();
      $display("t2 bounce done");

      // Multi-key priority and ordering
      press(16'h0006);
      release_key();
      press(16'h0020);
      release_key();
      press(16'h0080);
      release_key();
      chk("t3_count", 16'(bus.count), 16'd3);
      chk("t3_head0", 16'(bus.eBCD), 16'h11);
      bus.mode = 1'b1;
      step(1);
      chk("t3_head1", 16'(bus.eBCD), 16'h15);
      step(1);
      chk("t3_head2", 16'(bus.eBCD), 16'h17);
      step(1);
      chk("t3_empty", 16'(bus.eBCD), 16'h00);
      chk("t3_count0", 16'(bus.count), 16'd0);
      step(1);
      chk("t3_pop_empty", 16'(bus.count), 16'd0);
      bus.mode = 1'b0;
      $display("t3 ordering done");

      // Fill and overflow
      press(16'h0002); release_key();
      press(16'h0004); release_key();
      press(16'h0008); release_key();
      press(16'h0010); release_key();
      chk("t4_full", 16'(bus.full), 16'd1);
      chk("t4_count", 16'(bus.count), 16'd4);
      press(16'h0200);
      chk("t4_ovf_count", 16'(bus.count), 16'd4);
      chk("t4_ovf", 16'(bus.overflow), 16'd1);
      chk("t4_ovf_head", 16'(bus.eBCD), 16'h11);
      release_key();
      pop_one();
      chk("t4_pop1", 16'(bus.eBCD), 16'h12);
      pop_one();
      chk("t4_pop2", 16'(bus.eBCD), 16'h13);
      chk("t4_ovf_sticky", 16'(bus.overflow), 16'd1);
      $display("t4 overflow done");

      // AC flush with two entries queued
      bus.key_in = 16'h2000;
      step(3);
      chk("t5_pre_count", 16'(bus.count), 16'd2);
      chk("t5_pre_ac", 16'(bus.ac_pulse), 16'd0);
      step(1);
      chk("t5_count", 16'(bus.count), 16'd0);
      chk("t5_ebcd", 16'(bus.eBCD), 16'h00);
      chk("t5_ovf", 16'(bus.overflow), 16'd0);
      chk("t5_ac", 16'(bus.ac_pulse), 16'd1);
      step(1);
      chk("t5_ac_off", 16'(bus.ac_pulse), 16'd0);
      chk("t5_count_after", 16'(bus.count), 16'd0);
      release_key();
      $display("t5 ac flush done");

      // Push and pop on the same edge while full
      press(16'h0002); release_key();
      press(16'h0004); release_key();
      press(16'h0008); release_key();
      press(16'h0010); release_key();
      bus.key_in = 16'h0400;
      step(3);
      bus.mode = 1'b1;
      step(1);
      bus.mode = 1'b0;
      chk("t6_count", 16'(bus.count), 16'd4);
      chk("t6_ovf", 16'(bus.overflow), 16'd0);
      chk("t6_head", 16'(bus.eBCD), 16'h12);
      release_key();
      pop_one();
      chk("t6_pop1", 16'(bus.eBCD), 16'h13);
      pop_one();
      chk("t6_pop2", 16'(bus.eBCD), 16'h14);
      pop_one();
      chk("t6_pop3", 16'(bus.eBCD), 16'h1a);
      pop_one();
      chk("t6_pop4", 16'(bus.eBCD), 16'h00);
      $display("t6 full push+pop done");

      // Reset in the middle of a press
      press(16'h0020); release_key();
      press(16'h0040); release_key();
      press(16'h0080); release_key();
      chk("t7_pre_count", 16'(bus.count), 16'd3);
      bus.key_in = 16'h0100;
      step(2);
      rst = 1'b1;
      step(1);
      chk("t7_rst_ebcd", 16'(bus.eBCD), 16'h00);
      chk("t7_rst_count", 16'(bus.count), 16'd0);
      chk("t7_rst_full", 16'(bus.full), 16'd0);
      chk("t7_rst_ovf", 16'(bus.overflow), 16'd0);
      chk("t7_rst_ac", 16'(bus.ac_pulse), 16'd0);
      rst = 1'b0;
      step(3);
      chk("t7_early_count", 16'(bus.count), 16'd0);
      step(1);
      chk("t7_count", 16'(bus.count), 16'd1);
      chk("t7_ebcd", 16'(bus.eBCD), 16'h18);
      $display("t7 mid-press reset done");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
